// File: rtl/multichannel_fifo_controller.sv
// Controller for CHANNELS independent FIFOs sharing one statically partitioned memory.
// Each channel owns DEPTH contiguous entries and has its own wrap-bit pointers and level.
module multichannel_fifo_controller #(
    parameter int WIDTH                 = 8,
    parameter int DEPTH                 = 4,
    parameter int CHANNELS              = 4,
    parameter int ALMOST_FULL_THRESHOLD = DEPTH - 1,
    parameter int DEPTH_LOG2            = $clog2(DEPTH),
    parameter int CHANNELS_LOG2         = $clog2(CHANNELS)
) (
    input  logic                                   clock,
    input  logic                                   resetn,
    input  logic                                   write_enable,
    input  logic [CHANNELS_LOG2-1:0]               write_channel,
    input  logic [WIDTH-1:0]                       write_data,
    output logic [CHANNELS-1:0]                    write_full,
    output logic [CHANNELS-1:0]                    write_almost_full,
    output logic                                   write_overflow,
    input  logic                                   read_enable,
    input  logic [CHANNELS_LOG2-1:0]               read_channel,
    output logic [WIDTH-1:0]                       read_data,
    output logic [CHANNELS-1:0]                    read_empty,
    output logic                                   read_underflow,
    output logic [CHANNELS*(DEPTH_LOG2+1)-1:0]     level,
    output logic                                   memory_clock,
    output logic                                   memory_write_enable,
    output logic [CHANNELS_LOG2+DEPTH_LOG2-1:0]    memory_write_address,
    output logic [WIDTH-1:0]                       memory_write_data,
    output logic                                   memory_read_enable,
    output logic [CHANNELS_LOG2+DEPTH_LOG2-1:0]    memory_read_address,
    input  logic [WIDTH-1:0]                       memory_read_data
);

    localparam int LW = DEPTH_LOG2 + 1;

    logic [LW-1:0] wr_ptr_q [CHANNELS];
    logic [LW-1:0] wr_ptr_d [CHANNELS];
    logic [LW-1:0] rd_ptr_q [CHANNELS];
    logic [LW-1:0] rd_ptr_d [CHANNELS];
    logic [LW-1:0] level_q  [CHANNELS];
    logic [LW-1:0] level_d  [CHANNELS];
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          push_ok, pop_ok;

    // Status flags come only from registered level, never from same-cycle requests.
    always_comb begin
        write_full        = '0;
        read_empty        = '0;
        write_almost_full = '0;
        level             = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            write_full[c]        = (level_q[c] == LW'(DEPTH));
            read_empty[c]        = (level_q[c] == '0);
            write_almost_full[c] = (level_q[c] >= LW'(ALMOST_FULL_THRESHOLD));
            level[c*LW +: LW]    = level_q[c];
        end
    end

    assign push_ok = resetn && write_enable && !write_full[write_channel];
    assign pop_ok  = resetn && read_enable && !read_empty[read_channel];

    assign memory_clock         = clock;
    assign memory_write_enable  = push_ok;
    assign memory_write_address = {write_channel, wr_ptr_q[write_channel][DEPTH_LOG2-1:0]};
    assign memory_write_data    = write_data;
    assign memory_read_enable   = pop_ok;
    assign memory_read_address  = {read_channel, rd_ptr_q[read_channel][DEPTH_LOG2-1:0]};
    assign read_data            = memory_read_data;
    assign write_overflow       = overflow_q;
    assign read_underflow       = underflow_q;

    // Level is the wrap-aware pointer difference, so it lands in 0..DEPTH by construction.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            if (push_ok && (write_channel == CHANNELS_LOG2'(c))) begin
                wr_ptr_d[c] = wr_ptr_q[c] + LW'(1);
            end
            if (pop_ok && (read_channel == CHANNELS_LOG2'(c))) begin
                rd_ptr_d[c] = rd_ptr_q[c] + LW'(1);
            end
            level_d[c] = wr_ptr_d[c] - rd_ptr_d[c];
        end
        overflow_d  = write_enable && write_full[write_channel];
        underflow_d = read_enable && read_empty[read_channel];
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                level_q[c]  <= '0;
            end
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                level_q[c]  <= level_d[c];
            end
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
